// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: in-flight entry record and forward-select type.
// Address fields are sized to AW_MAX; narrower register files zero-extend into them.
package hazard_pkg;

    localparam int AW_MAX = 8;
    localparam int SW_MAX = 3;

    typedef struct packed {
        logic              valid;
        logic [AW_MAX-1:0] raddr;
        logic              regwrite;
        logic              memread;
        logic [AW_MAX-1:0] rs;
        logic [AW_MAX-1:0] rt;
    } entry_t;

    typedef logic [SW_MAX-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 3'd0;

    function automatic entry_t bubble();
        entry_t e;
        e = '0;
        return e;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source address against every in-flight entry selected by mask;
// returns the hit vector and the index of the youngest (lowest) hit.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int SW     = $clog2(NSTAGE)
) (
    input  logic [AW_MAX-1:0]         addr,
    input  entry_t [NSTAGE-1:0]       ents,
    input  logic [NSTAGE-1:0]         mask,
    output logic [NSTAGE-1:0]         hit,
    output logic [SW-1:0]             youngest
);

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit      = '0;
        youngest = SW'(FWD_REGFILE);
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (mask[k] && (addr != '0) && ents[k].valid && ents[k].regwrite &&
                (ents[k].raddr == addr)) begin
                hit[k]   = 1'b1;
                youngest = SW'(k);
            end else begin
                hit[k]   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush of F/D and E-operand forwarding selects.
// Define HAZARD_FORWARD_EN for forwarding (load-use stalls only); otherwise stall-only.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int SW     = $clog2(NSTAGE)
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          IssueValidD,
    input  logic [AW-1:0] RsAddrD,
    input  logic [AW-1:0] RtAddrD,
    input  logic [AW-1:0] RAddrD,
    input  logic          RegWriteD,
    input  logic          MemReadD,
    input  logic          BranchTakenE,
    output logic          StallFD,
    output logic          FlushD,
    output logic [SW-1:0] ForwardA,
    output logic [SW-1:0] ForwardB,
    output logic [15:0]   StallCount
);

`ifdef HAZARD_FORWARD_EN
    localparam logic [NSTAGE-1:0] MASK_D = {{(NSTAGE-1){1'b0}}, 1'b1};
    localparam logic [NSTAGE-1:0] MASK_E = {{(NSTAGE-1){1'b1}}, 1'b0};
`else
    // The W entry is excluded: the register file writes before it is read.
    localparam logic [NSTAGE-1:0] MASK_D = {1'b0, {(NSTAGE-1){1'b1}}};
`endif

    entry_t [NSTAGE-1:0] ents;
    entry_t              new_ent;
    logic [AW_MAX-1:0]   rs_d, rt_d, rd_d;
    logic [NSTAGE-1:0]   hit_rs_d, hit_rt_d;
    logic [SW-1:0]       yng_rs_d, yng_rt_d;
    logic                haz_rs, haz_rt, stall_raw, load_d;

    // Zero-extend decode addresses into the entry field width.
    always_comb begin
        rs_d = '0;
        rt_d = '0;
        rd_d = '0;
        rs_d[AW-1:0] = RsAddrD;
        rt_d[AW-1:0] = RtAddrD;
        rd_d[AW-1:0] = RAddrD;
    end

    hazard_match #(.NSTAGE(NSTAGE), .SW(SW)) u_match_rs_d (
        .addr(rs_d), .ents(ents), .mask(MASK_D), .hit(hit_rs_d), .youngest(yng_rs_d)
    );
    hazard_match #(.NSTAGE(NSTAGE), .SW(SW)) u_match_rt_d (
        .addr(rt_d), .ents(ents), .mask(MASK_D), .hit(hit_rt_d), .youngest(yng_rt_d)
    );

    // The youngest hit is itself a hit whenever any masked entry matched.
`ifdef HAZARD_FORWARD_EN
    assign haz_rs = hit_rs_d[yng_rs_d] && ents[yng_rs_d].memread;
    assign haz_rt = hit_rt_d[yng_rt_d] && ents[yng_rt_d].memread;
`else
    assign haz_rs = hit_rs_d[yng_rs_d];
    assign haz_rt = hit_rt_d[yng_rt_d];
`endif

    assign stall_raw = IssueValidD && (haz_rs || haz_rt);
    assign StallFD   = stall_raw && !BranchTakenE;
    assign FlushD    = BranchTakenE;
    assign load_d    = IssueValidD && !StallFD && !BranchTakenE;

`ifdef HAZARD_FORWARD_EN
    logic [NSTAGE-1:0] hit_rs_e, hit_rt_e;
    logic [SW-1:0]     yng_rs_e, yng_rt_e;

    hazard_match #(.NSTAGE(NSTAGE), .SW(SW)) u_match_rs_e (
        .addr(ents[0].rs), .ents(ents), .mask(MASK_E), .hit(hit_rs_e), .youngest(yng_rs_e)
    );
    hazard_match #(.NSTAGE(NSTAGE), .SW(SW)) u_match_rt_e (
        .addr(ents[0].rt), .ents(ents), .mask(MASK_E), .hit(hit_rt_e), .youngest(yng_rt_e)
    );

    assign ForwardA = (ents[0].valid && hit_rs_e[yng_rs_e]) ? yng_rs_e : SW'(FWD_REGFILE);
    assign ForwardB = (ents[0].valid && hit_rt_e[yng_rt_e]) ? yng_rt_e : SW'(FWD_REGFILE);
`else
    assign ForwardA = SW'(FWD_REGFILE);
    assign ForwardB = SW'(FWD_REGFILE);
`endif

    // Build the record entering E: the decode instruction or a bubble.
    always_comb begin
        new_ent = bubble();
        if (load_d) begin
            new_ent.valid    = 1'b1;
            new_ent.raddr    = rd_d;
            new_ent.regwrite = RegWriteD;
            new_ent.memread  = MemReadD;
            new_ent.rs       = rs_d;
            new_ent.rt       = rt_d;
        end else begin
            new_ent = bubble();
        end
    end

    // In-flight shift register: entry k moves to k+1, the W entry retires.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ents <= '0;
        end else begin
            ents <= {ents[NSTAGE-2:0], new_ent};
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            StallCount <= 16'd0;
        end else if (StallFD && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end else begin
            StallCount <= StallCount;
        end
    end

endmodule
